// File: rtl/fetch_control.sv
// rtl/fetch_control.sv - in-order instruction fetch sequencer with response FIFO and branch redirect
// Credits bound outstanding requests plus buffered words to DEPTH, so the FIFO can never overflow.
module fetch_control #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        pc_v_x_i,
  input  logic [31:0] pc_x_i,
  input  logic        halt_i,
  output logic [31:0] pc_o,
  output logic        inst_v_o,
  output logic [31:0] inst_o,
  output logic        busy_o
);

  localparam int          PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int          CW      = $clog2(DEPTH + 1);
  localparam logic [CW:0] CREDITS = (CW + 1)'(DEPTH);

  // Addresses are word aligned, so only bits [31:2] are stored anywhere.
  logic [29:0]   fpc, fpc_n;
  logic [CW-1:0] outstanding, outstanding_n;
  logic [CW-1:0] drop_cnt, drop_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [CW:0]   in_use;

  logic [29:0]   fifo_pc   [DEPTH];
  logic [31:0]   fifo_inst [DEPTH];
  logic [PW-1:0] f_rd, f_wr;

  logic [29:0]   aq [DEPTH];
  logic [PW-1:0] aq_rd, aq_wr;

  logic fire;
  logic push;
  logic pop;
  logic unused_bits;

  assign unused_bits = ^pc_x_i[1:0];

  assign in_use      = {1'b0, outstanding} + {1'b0, cnt};
  assign imem_req_o  = reset & ~halt_i & ~pc_v_x_i & (in_use < CREDITS);
  assign imem_addr_o = {fpc, 2'b00};
  assign fire        = imem_req_o & imem_gnt_i;

  assign inst_v_o = reset & (cnt != '0) & ~pc_v_x_i & ~halt_i;
  assign pc_o     = {fifo_pc[f_rd], 2'b00};
  assign inst_o   = fifo_inst[f_rd];
  assign pop      = inst_v_o;

  // A word landing in a redirect cycle is wrong-path even when drop is zero.
  assign push   = imem_rvalid_i & (drop_cnt == '0) & ~pc_v_x_i;
  assign busy_o = (outstanding != '0) | (cnt != '0);

  always_comb begin
    fpc_n         = fpc;
    drop_n        = drop_cnt;
    cnt_n         = cnt;
    outstanding_n = outstanding + CW'(fire) - CW'(imem_rvalid_i);
    if (fire) begin
      fpc_n = fpc + 30'd1;
    end
    if (pc_v_x_i) begin
      fpc_n  = pc_x_i[31:2];
      // Every response still in flight after this edge belongs to the old path.
      drop_n = outstanding - CW'(imem_rvalid_i);
      cnt_n  = '0;
    end else begin
      if (imem_rvalid_i && (drop_cnt != '0)) begin
        drop_n = drop_cnt - CW'(1);
      end
      cnt_n = cnt + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fpc         <= RESET_PC[31:2];
      outstanding <= '0;
      drop_cnt    <= '0;
      cnt         <= '0;
      f_rd        <= '0;
      f_wr        <= '0;
      aq_rd       <= '0;
      aq_wr       <= '0;
    end else begin
      fpc         <= fpc_n;
      outstanding <= outstanding_n;
      drop_cnt    <= drop_n;
      cnt         <= cnt_n;
      if (fire) begin
        aq_wr <= aq_wr + PW'(1);
      end
      if (imem_rvalid_i) begin
        aq_rd <= aq_rd + PW'(1);
      end
      if (pc_v_x_i) begin
        f_rd <= '0;
        f_wr <= '0;
      end else begin
        if (push) begin
          f_wr <= f_wr + PW'(1);
        end
        if (pop) begin
          f_rd <= f_rd + PW'(1);
        end
      end
    end
  end

  // Storage carries no reset; validity is tracked by the pointers and counts.
  always_ff @(posedge clk) begin
    if (fire) begin
      aq[aq_wr] <= fpc;
    end
    if (push) begin
      fifo_pc[f_wr]   <= aq[aq_rd];
      fifo_inst[f_wr] <= imem_rdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      if (imem_rvalid_i) begin
        assert (outstanding != '0);
      end
      if (push) begin
        assert (cnt < CW'(DEPTH));
      end
    end
  end

endmodule
